// File: rtl/exc_ctrl.sv
// Exception and interrupt controller: prioritises opcode/overflow exceptions and masked IRQs,
// captures EPC/Cause, issues a one-cycle vector pulse and tracks handler residency until eret.
module exc_ctrl #(
  parameter int              WIDTH    = 32,
  parameter int              N_IRQ    = 4,
  parameter logic [WIDTH-1:0] VEC_BASE = 'h80,
  localparam int             CW       = $clog2(N_IRQ + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exc_opcode,
  input  logic             exc_ovf,
  input  logic [N_IRQ-1:0] irq,
  input  logic             instr_boundary,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_din,
  output logic             take,
  output logic [WIDTH-1:0] pc_vec,
  output logic [WIDTH-1:0] epc,
  output logic [CW-1:0]    cause,
  output logic             in_handler,
  output logic             double_fault,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VECTOR  = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] scan;
  logic             irq_found;
  logic [CW-1:0]    irq_cause;
  logic             ev;
  logic [CW-1:0]    ev_cause;
  logic [WIDTH-1:0] vec_nxt;
  logic             df_set;

  assign pending = irq & mask;
  assign vec_nxt = VEC_BASE + (WIDTH'(ev_cause) << 2);
  assign df_set  = (state == HANDLER) && (exc_opcode || exc_ovf);

  // Lowest-numbered pending line wins; scan shifts right so only bit 0 is ever inspected.
  always_comb begin
    scan      = pending;
    irq_found = 1'b0;
    irq_cause = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      if (!irq_found && scan[0]) begin
        irq_found = 1'b1;
        irq_cause = CW'(k + 2);
      end
      scan = scan >> 1;
    end
  end

  always_comb begin
    ev       = 1'b0;
    ev_cause = '0;
    if (state == IDLE) begin
      if (exc_opcode) begin
        ev       = 1'b1;
        ev_cause = CW'(0);
      end else if (exc_ovf) begin
        ev       = 1'b1;
        ev_cause = CW'(1);
      end else if (instr_boundary && irq_found) begin
        ev       = 1'b1;
        ev_cause = irq_cause;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ev) state_nxt = VECTOR;
      VECTOR:  state_nxt = HANDLER;
      HANDLER: if (eret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      take         <= 1'b0;
      pc_vec       <= VEC_BASE;
      epc          <= '0;
      cause        <= '0;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
      mask         <= '0;
    end else begin
      state      <= state_nxt;
      take       <= ev;
      in_handler <= (state_nxt != IDLE);
      if (ev) begin
        epc    <= pc_cur;
        cause  <= ev_cause;
        pc_vec <= vec_nxt;
      end
      if (df_set) double_fault <= 1'b1;
      if (mask_we) mask <= mask_din;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a behavioural model predicts each cycle's outputs and
// queues expected vector events; a negedge monitor pops and compares.
module tb_exc_ctrl;
  localparam int          WIDTH    = 32;
  localparam int          N_IRQ    = 4;
  localparam logic [31:0] VEC_BASE = 32'h80;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exc_opcode = 1'b0;
  logic        exc_ovf = 1'b0;
  logic [3:0]  irq = '0;
  logic        instr_boundary = 1'b0;
  logic [31:0] pc_cur = '0;
  logic        eret = 1'b0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_din = '0;
  logic        take;
  logic [31:0] pc_vec;
  logic [31:0] epc;
  logic [2:0]  cause;
  logic        in_handler;
  logic        double_fault;
  logic [3:0]  pending;

  exc_ctrl #(.WIDTH(WIDTH), .N_IRQ(N_IRQ), .VEC_BASE(VEC_BASE)) dut (
    .clock(clock), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .irq(irq), .instr_boundary(instr_boundary), .pc_cur(pc_cur), .eret(eret),
    .mask_we(mask_we), .mask_din(mask_din), .take(take), .pc_vec(pc_vec),
    .epc(epc), .cause(cause), .in_handler(in_handler),
    .double_fault(double_fault), .pending(pending)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] pc_vec;
    logic [31:0] epc;
    logic [2:0]  cause;
  } exp_t;
  exp_t sb[$];

  // Reference model: handler residency as two flags, events chosen by the priority rules.
  logic        m_valid = 1'b0;
  logic        m_after_reset = 1'b0;
  logic        m_in_h = 1'b0;
  logic        m_vec = 1'b0;
  logic        m_df = 1'b0;
  logic [3:0]  m_mask = '0;
  logic [31:0] m_epc = '0;
  logic [2:0]  m_cause = '0;
  logic [3:0]  m_scan;
  int          m_c;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1; m_after_reset = 1'b1;
      m_in_h = 1'b0; m_vec = 1'b0; m_df = 1'b0;
      m_mask = '0; m_epc = '0; m_cause = '0;
    end else begin
      m_after_reset = 1'b0;
      m_c = -1;
      if (!m_in_h) begin
        if (exc_opcode) m_c = 0;
        else if (exc_ovf) m_c = 1;
        else if (instr_boundary) begin
          m_scan = irq & m_mask;
          for (int k = 0; k < N_IRQ; k++) begin
            if (m_c < 0 && m_scan[0]) m_c = 2 + k;
            m_scan = m_scan >> 1;
          end
        end
        if (m_c >= 0) begin
          m_in_h = 1'b1; m_vec = 1'b1;
          m_epc = pc_cur; m_cause = 3'(m_c);
          sb.push_back('{VEC_BASE + 32'(4 * m_c), pc_cur, 3'(m_c)});
        end
      end else if (m_vec) begin
        m_vec = 1'b0;
      end else begin
        if (exc_opcode || exc_ovf) m_df = 1'b1;
        if (eret) m_in_h = 1'b0;
      end
      if (mask_we) m_mask = mask_din;
    end
  end

  exp_t e;
  always @(negedge clock) begin
    if (m_valid) begin
      chk("take", {31'b0, take}, (sb.size() != 0) ? 32'd1 : 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (take === 1'b1) begin
          chk("take_pc_vec", pc_vec, e.pc_vec);
          chk("take_epc", epc, e.epc);
          chk("take_cause", {29'b0, cause}, {29'b0, e.cause});
        end
      end
      chk("in_handler", {31'b0, in_handler}, {31'b0, m_in_h});
      chk("double_fault", {31'b0, double_fault}, {31'b0, m_df});
      chk("epc", epc, m_epc);
      chk("cause", {29'b0, cause}, {29'b0, m_cause});
      chk("pending", {28'b0, pending}, {28'b0, irq & m_mask});
      if (m_after_reset) chk("reset_pc_vec", pc_vec, VEC_BASE);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_take", {31'b0, take}, 32'd0);
    chk("rst_pc_vec", pc_vec, 32'h80);
    chk("rst_epc", epc, 32'h0);
    chk("rst_in_handler", {31'b0, in_handler}, 32'd0);

    // masked interrupts never taken
    irq = 4'hf;
    repeat (20) step();
    chk("mask0_pending", {28'b0, pending}, 32'd0);
    irq = '0;

    // overflow exception
    pc_cur = 32'h40; exc_ovf = 1'b1;
    step();
    exc_ovf = 1'b0;
    chk("ovf_take", {31'b0, take}, 32'd1);
    chk("ovf_pc_vec", pc_vec, 32'h84);
    chk("ovf_cause", {29'b0, cause}, 32'd1);
    chk("ovf_epc", epc, 32'h40);
    step(); step();
    eret = 1'b1; step(); eret = 1'b0;
    chk("ovf_eret", {31'b0, in_handler}, 32'd0);

    // priority, then the deferred interrupt
    mask_we = 1'b1; mask_din = 4'hf; step(); mask_we = 1'b0;
    exc_opcode = 1'b1; exc_ovf = 1'b1; irq = 4'b0010; instr_boundary = 1'b1;
    step();
    exc_opcode = 1'b0; exc_ovf = 1'b0;
    chk("prio_cause", {29'b0, cause}, 32'd0);
    chk("prio_pc_vec", pc_vec, 32'h80);
    step();
    eret = 1'b1; step(); eret = 1'b0;
    step();
    chk("irq1_take", {31'b0, take}, 32'd1);
    chk("irq1_cause", {29'b0, cause}, 32'd3);
    chk("irq1_pc_vec", pc_vec, 32'h8c);
    irq = '0; instr_boundary = 1'b0;
    step();
    eret = 1'b1; step(); eret = 1'b0;

    // interrupts wait for an instruction boundary
    mask_we = 1'b1; mask_din = 4'b0100; step(); mask_we = 1'b0;
    irq = 4'b0100; instr_boundary = 1'b0;
    repeat (5) step();
    chk("noboundary_take", {31'b0, take}, 32'd0);
    pc_cur = 32'h100; instr_boundary = 1'b1;
    step();
    chk("irq2_take", {31'b0, take}, 32'd1);
    chk("irq2_cause", {29'b0, cause}, 32'd4);
    chk("irq2_pc_vec", pc_vec, 32'h90);
    chk("irq2_epc", epc, 32'h100);
    irq = '0; instr_boundary = 1'b0;

    // double fault
    step();
    exc_opcode = 1'b1; step(); exc_opcode = 1'b0;
    chk("df_set", {31'b0, double_fault}, 32'd1);
    chk("df_epc", epc, 32'h100);
    chk("df_cause", {29'b0, cause}, 32'd4);
    chk("df_notake", {31'b0, take}, 32'd0);
    eret = 1'b1; step(); eret = 1'b0;
    chk("df_eret_idle", {31'b0, in_handler}, 32'd0);
    repeat (3) step();
    chk("df_sticky", {31'b0, double_fault}, 32'd1);

    // reset during the vector cycle
    exc_opcode = 1'b1; step(); exc_opcode = 1'b0;
    chk("vec_take", {31'b0, take}, 32'd1);
    reset = 1'b1; irq = 4'hf; step(); reset = 1'b0;
    chk("rstvec_take", {31'b0, take}, 32'd0);
    chk("rstvec_in_handler", {31'b0, in_handler}, 32'd0);
    chk("rstvec_df", {31'b0, double_fault}, 32'd0);
    chk("rstvec_pending", {28'b0, pending}, 32'd0);
    irq = '0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 149) == 0);
      exc_opcode     = ($urandom_range(0, 15) == 0);
      exc_ovf        = ($urandom_range(0, 15) == 0);
      irq            = 4'($urandom);
      instr_boundary = 1'($urandom_range(0, 1));
      eret           = ($urandom_range(0, 3) == 0);
      mask_we        = ($urandom_range(0, 11) == 0);
      mask_din       = 4'($urandom);
      pc_cur         = $urandom;
      step();
    end

    reset = 1'b0; exc_opcode = 1'b0; exc_ovf = 1'b0; irq = '0;
    eret = 1'b0; mask_we = 1'b0; instr_boundary = 1'b0;
    repeat (3) step();
    chk("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
